// File: rtl/context_scheduler_pkg.sv
// Shared constants for the round-robin context scheduler.
// Optional preemption is enabled by defining CTX_SCHED_PREEMPT_EN.
package ctx_sched_pkg;

  localparam int unsigned N_PROC          = 4;
  localparam int unsigned PC_WIDTH        = 10;
  localparam int unsigned QUANTUM_WIDTH   = 16;
  localparam int unsigned DEFAULT_QUANTUM = 1000;
  localparam int unsigned CTX_W           = $clog2(N_PROC);

  localparam logic [CTX_W-1:0] OS_CTX = '0;

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_SAVE    = 3'd1;
  localparam logic [2:0] ST_SELECT  = 3'd2;
  localparam logic [2:0] ST_RESTORE = 3'd3;
  localparam logic [2:0] ST_DEAD    = 3'd4;

endpackage

// File: rtl/context_scheduler_if.sv
// Decoder/pipeline-side bundle of the context scheduler.
// master = pipeline/decoder side, slave = scheduler.
interface context_scheduler_if #(
  parameter int unsigned N_PROC        = ctx_sched_pkg::N_PROC,
  parameter int unsigned PC_WIDTH      = ctx_sched_pkg::PC_WIDTH,
  parameter int unsigned QUANTUM_WIDTH = ctx_sched_pkg::QUANTUM_WIDTH
);
  logic                      Change_Context;
  logic                      Halt;
  logic [PC_WIDTH-1:0]       Cur_PC;
  logic [N_PROC-1:0]         Ready_Mask;
  logic [QUANTUM_WIDTH-1:0]  Quantum;
  logic                      Quantum_Load;
  logic                      Stall;
  logic                      PC_Load;
  logic [PC_WIDTH-1:0]       PC_Next;
  logic [$clog2(N_PROC)-1:0] Ctx_Id;
  logic                      Ctx_Switch;
  logic                      Sys_Halt;

  modport master (
    output Change_Context, Halt, Cur_PC, Ready_Mask, Quantum, Quantum_Load,
    input  Stall, PC_Load, PC_Next, Ctx_Id, Ctx_Switch, Sys_Halt
  );

  modport slave (
    input  Change_Context, Halt, Cur_PC, Ready_Mask, Quantum, Quantum_Load,
    output Stall, PC_Load, PC_Next, Ctx_Id, Ctx_Switch, Sys_Halt
  );
endinterface

// File: rtl/context_scheduler_rr_picker.sv
// Combinational round-robin picker: first eligible context after cur_id_i,
// wrapping modulo N_PROC, with cur_id_i itself considered last.
module rr_picker #(
  parameter int unsigned N_PROC = 4
) (
  input  logic [N_PROC-1:0]         eligible_i,
  input  logic [$clog2(N_PROC)-1:0] cur_id_i,
  output logic [$clog2(N_PROC)-1:0] next_id_c,
  output logic                      none_eligible_c
);
  localparam int unsigned CW = $clog2(N_PROC);

  logic [CW-1:0] idx;

  // Walk from farthest to nearest so the nearest eligible id wins.
  always_comb begin
    next_id_c       = cur_id_i;
    none_eligible_c = 1'b1;
    idx             = cur_id_i;
    for (int i = int'(N_PROC); i > 0; i--) begin
      idx = cur_id_i + CW'(i);
      if (eligible_i[idx]) begin
        next_id_c       = idx;
        none_eligible_c = 1'b0;
      end
    end
  end
endmodule

// File: rtl/context_scheduler.sv
// Round-robin context scheduler: save/select/restore sequencing, PC table,
// halted flags, optional quantum preemption (CTX_SCHED_PREEMPT_EN).
module context_scheduler
  import ctx_sched_pkg::*;
#(
  parameter int unsigned N_PROC          = ctx_sched_pkg::N_PROC,
  parameter int unsigned PC_WIDTH        = ctx_sched_pkg::PC_WIDTH,
  parameter int unsigned QUANTUM_WIDTH   = ctx_sched_pkg::QUANTUM_WIDTH,
  parameter int unsigned DEFAULT_QUANTUM = ctx_sched_pkg::DEFAULT_QUANTUM
) (
  input logic                 Clock,
  input logic                 Reset,
  context_scheduler_if.slave  sif
);
  localparam int unsigned CW = $clog2(N_PROC);

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       ctx_q, ctx_d;
  logic [N_PROC-1:0]   halted_q, halted_d;
  logic [PC_WIDTH-1:0] pc_tab_q [N_PROC];
  logic [PC_WIDTH-1:0] pc_tab_d [N_PROC];
  logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
  logic                stall_q, stall_d;
  logic                pc_load_q, pc_load_d;
  logic                ctx_switch_q, ctx_switch_d;
  logic                sys_halt_q, sys_halt_d;

  logic [N_PROC-1:0]   eligible_c;
  logic [CW-1:0]       pick_id_c;
  logic                pick_none_c;
  logic                expiry_c;
  logic                trigger_c;

`ifdef CTX_SCHED_PREEMPT_EN
  logic [QUANTUM_WIDTH-1:0] quantum_q, quantum_d;
  logic [QUANTUM_WIDTH-1:0] cnt_q, cnt_d;

  // Counter runs only in RUN and is reloaded as the new context resumes.
  always_comb begin
    quantum_d = sif.Quantum_Load ? sif.Quantum : quantum_q;
    cnt_d     = cnt_q;
    if (state_q == ST_RUN)     cnt_d = cnt_q - QUANTUM_WIDTH'(1);
    if (state_q == ST_RESTORE) cnt_d = quantum_q;
  end

  assign expiry_c = (state_q == ST_RUN) && (cnt_q == QUANTUM_WIDTH'(1)) &&
                    (quantum_q != '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      quantum_q <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      cnt_q     <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
    end else begin
      quantum_q <= quantum_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  logic [QUANTUM_WIDTH-1:0] unused_quantum;
  logic                     unused_quantum_load;
  assign unused_quantum      = sif.Quantum ^ QUANTUM_WIDTH'(DEFAULT_QUANTUM);
  assign unused_quantum_load = sif.Quantum_Load;
  assign expiry_c            = 1'b0;
`endif

  // The OS context is always considered loaded.
  assign eligible_c = (sif.Ready_Mask | N_PROC'(1)) & ~halted_q;
  assign trigger_c  = sif.Halt | sif.Change_Context | expiry_c;

  rr_picker #(.N_PROC(N_PROC)) u_picker (
    .eligible_i      (eligible_c),
    .cur_id_i        (ctx_q),
    .next_id_c       (pick_id_c),
    .none_eligible_c (pick_none_c)
  );

  always_comb begin
    state_d      = state_q;
    ctx_d        = ctx_q;
    halted_d     = halted_q;
    pc_tab_d     = pc_tab_q;
    pc_next_d    = pc_next_q;
    pc_load_d    = 1'b0;
    ctx_switch_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (trigger_c) begin
          state_d = ST_SAVE;
          if (sif.Halt) halted_d[ctx_q] = 1'b1;
        end
      end
      ST_SAVE: begin
        pc_tab_d[ctx_q] = sif.Cur_PC;
        state_d         = ST_SELECT;
      end
      ST_SELECT: begin
        if (pick_none_c) begin
          state_d = ST_DEAD;
        end else begin
          state_d      = ST_RESTORE;
          ctx_d        = pick_id_c;
          pc_next_d    = pc_tab_q[pick_id_c];
          pc_load_d    = 1'b1;
          ctx_switch_d = (pick_id_c != ctx_q);
        end
      end
      ST_RESTORE: state_d = ST_RUN;
      ST_DEAD:    state_d = ST_DEAD;
      default:    state_d = ST_RUN;
    endcase
    stall_d    = (state_d != ST_RUN);
    sys_halt_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_RUN;
      ctx_q        <= OS_CTX;
      halted_q     <= '0;
      pc_tab_q     <= '{default: '0};
      pc_next_q    <= '0;
      stall_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      ctx_switch_q <= 1'b0;
      sys_halt_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctx_q        <= ctx_d;
      halted_q     <= halted_d;
      pc_tab_q     <= pc_tab_d;
      pc_next_q    <= pc_next_d;
      stall_q      <= stall_d;
      pc_load_q    <= pc_load_d;
      ctx_switch_q <= ctx_switch_d;
      sys_halt_q   <= sys_halt_d;
    end
  end

  assign sif.Stall      = stall_q;
  assign sif.PC_Load    = pc_load_q;
  assign sif.PC_Next    = pc_next_q;
  assign sif.Ctx_Id     = ctx_q;
  assign sif.Ctx_Switch = ctx_switch_q;
  assign sif.Sys_Halt   = sys_halt_q;
endmodule
